add_sub_seq: RTL and testbench

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

---
 rtl/add_sub_seq_if.sv | 30 +++
 rtl/add_sub_seq.sv | 131 +++++++++++++
 tb/tb_add_sub_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/add_sub_seq_if.sv
// add_sub_seq_if -- operand/result handshake bundle for add_sub_seq.
//   in_valid/in_ready : operand handshake (a, b, sub qualified by in_valid)
//   out_valid/out_ready: result handshake (result, c, v, z qualified by out_valid)
//   master : producer of operands / consumer of results
//   slave  : the sequential adder
interface add_sub_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c;
  logic             v;
  logic             z;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, c, v, z
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, c, v, z
  );
endinterface

// File: rtl/add_sub_seq.sv
// add_sub_seq -- bit-serial-by-slice adder/subtractor.
//   Adds SLICE bits per cycle (LSB slice first) through a carry register,
//   then presents RESULT with carry (C), signed overflow (V) and zero (Z)
//   under a valid/ready handshake.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : add_sub_seq_if.slave (in_valid/in_ready/a/b/sub,
//           out_valid/out_ready/result/c/v/z)
// Parameters: WIDTH (operand width), SLICE (bits per cycle, divides WIDTH).
// Optional feature macro: ADD_SUB_SAT_EN -- saturate RESULT on signed
//   overflow (C and V still report the raw carry/overflow).
// Latency: OUT_VALID rises WIDTH/SLICE+1 cycles after the accept edge; the
//   extra cycle past the last slice is spent in DONE forming the flags from
//   the fully assembled sum.
module add_sub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  add_sub_seq_if.slave  bus
);
  localparam int NSL   = WIDTH / SLICE;
  localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // operand after optional inversion (Bop)
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_c;
  logic             r_v;
  logic             r_z;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_sum_sl;
  logic             w_cout;
  logic             w_last;
  logic             w_v;
  logic [WIDTH-1:0] w_final;
  logic             w_z;

  assign w_a_sl = r_a[r_cnt*SLICE +: SLICE];
  assign w_b_sl = r_b[r_cnt*SLICE +: SLICE];
  assign {w_cout, w_sum_sl} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
  assign w_last = (r_cnt == CNT_W'(NSL - 1));

  // Overflow: operands agree in sign but the sum does not.
  assign w_v = (r_a[MSB] == r_b[MSB]) && (r_sum[MSB] != r_a[MSB]);

`ifdef ADD_SUB_SAT_EN
  // Clamp toward the sign of A: positive overflow -> max, negative -> min.
  assign w_final = !w_v ? r_sum :
                   r_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_final = r_sum;
`endif

  assign w_z = (w_final == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_z         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.sub ? ~bus.b : bus.b;
            r_carry    <= bus.sub;  // +1 completes the two's-complement negate
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_sum[r_cnt*SLICE +: SLICE] <= w_sum_sl;
          r_carry                     <= w_cout;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (!r_out_valid) begin
            // First DONE cycle: sum is complete, latch result and flags.
            r_result    <= w_final;
            r_c         <= r_carry;
            r_v         <= w_v;
            r_z         <= w_z;
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.c         = r_c;
  assign bus.v         = r_v;
  assign bus.z         = r_z;
endmodule

// File: tb/tb_add_sub_seq.sv
module tb_add_sub_seq;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  add_sub_seq_if #(.WIDTH(W)) bus();
  add_sub_seq #(.WIDTH(W), .SLICE(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact signed/unsigned arithmetic, then range checks.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic v, output logic z);
    longint          sa, sb, ex;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ex = s ? sa - sb : sa + sb;
    v  = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
    c  = s ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
    r  = ex[W-1:0];
`ifdef ADD_SUB_SAT_EN
    if (v) r = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    z  = (r == '0);
  endtask

  // One full transaction; inputs are scrambled (with in_valid held high)
  // while the operation is in flight.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r, output logic c, output logic v,
                        output logic z, output int lat);
    int guard;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom_range(0, 1));
    chk("in_ready_in_calc", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    r = bus.result; c = bus.c; v = bus.v; z = bus.z;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("in_ready_after_handshake", 64'(bus.in_ready), 64'd1);
    chk("out_valid_dropped", 64'(bus.out_valid), 64'd0);
  endtask

  vec_t         tbl[7];
  logic [W-1:0] r, er;
  logic         c, v, z, ec, ev, ez;
  int           lat;
  int           guard;
  logic         seen;
  logic [W-1:0] ra, rb;
  logic         rs;
  logic [W-1:0] specials[6];

  initial begin
    n_tests = 0; n_fail = 0;
    tbl[0] = '{32'd5, 32'd3, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'd5, 32'd3, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
`ifdef ADD_SUB_SAT_EN
    tbl[3] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
    tbl[3] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
`endif
    tbl[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
    specials = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_00FF};

    // Reset state
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_flags", 64'({bus.c, bus.v, bus.z}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, r, c, v, z, lat);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd5);
      chk($sformatf("tbl%0d_result", i), 64'(r), 64'(tbl[i].res));
      chk($sformatf("tbl%0d_cvz", i), 64'({c, v, z}), 64'({tbl[i].c, tbl[i].v, tbl[i].z}));
    end

    // Backpressure: hold DONE for 10 cycles while inputs churn
    @(negedge clk);
    bus.a = 32'd5; bus.b = 32'd3; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("bp_out_valid_rise", 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      bus.a = $urandom; bus.b = $urandom; bus.in_valid = 1'(k & 1);
      @(posedge clk); #1;
      chk("bp_result_hold", 64'(bus.result), 64'd8);
      chk("bp_flags_hold", 64'({bus.c, bus.v, bus.z}), 64'd0);
      chk("bp_out_valid_hold", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_no_same_cycle_accept", 64'(bus.in_ready), 64'd1);

    // Reset during the second CALC cycle
    @(negedge clk);
    bus.a = 32'd9; bus.b = 32'd9; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_result", 64'(bus.result), 64'd0);
    chk("midrst_flags_valid", 64'({bus.out_valid, bus.c, bus.v, bus.z}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    run_op(32'd1, 32'd1, 1'b0, r, c, v, z, lat);
    chk("midrst_next_result", 64'(r), 64'd2);
    chk("midrst_next_latency", 64'(lat), 64'd5);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, er, ec, ev, ez);
      run_op(ra, rb, rs, r, c, v, z, lat);
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'd5);
      chk($sformatf("rnd%0d_result a=%h b=%h s=%0d", i, ra, rb, rs), 64'(r), 64'(er));
      chk($sformatf("rnd%0d_cvz", i), 64'({c, v, z}), 64'({ec, ev, ez}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
